// File: rtl/pool_feeder.sv
// Window sequencer for the max-pooling comparator: walks KxK windows of a
// tile in RAM, streams each window to scmp and writes back its result.
module pool_feeder #(
  parameter int DW   = 16,
  parameter int AW   = 12,
  parameter int DIMW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      kernel,
  input  logic [3:0]      stride,
  input  logic [DIMW-1:0] in_w,
  input  logic [DIMW-1:0] in_h,
  input  logic [AW-1:0]   in_base,
  input  logic [AW-1:0]   out_base,
  output logic            rd_en,
  output logic [AW-1:0]   rd_addr,
  input  logic [DW-1:0]   rd_data,
  output logic [DW-1:0]   data,
  output logic            data_valid,
  input  logic            data_ready,
  output logic            pool_valid,
  input  logic            cmp_ready,
  input  logic [DW-1:0]   result,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [DW-1:0]   wr_data,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int CW = DIMW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_LAT, S_SEND, S_DRAIN, S_WR, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      k_q, k_d, s_q, s_d;
  logic [3:0]      kx_q, kx_d, ky_q, ky_d;
  logic [DIMW-1:0] w_q, w_d, h_q, h_d;
  logic [DIMW-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [AW-1:0]   ib_q, ib_d, ob_q, ob_d;
  logic [AW-1:0]   win_q, win_d;
  logic [DW-1:0]   data_q, data_d;
  logic [DW-1:0]   wd_q, wd_d;
  logic            err_q, err_d;

  logic            bad_cfg, kx_last, ky_last;
  logic            col_fits, row_fits;
  logic [DIMW-1:0] row, col;
  logic [AW-1:0]   rd_addr_c;

  assign kx_last = (kx_q == k_q - 4'd1);
  assign ky_last = (ky_q == k_q - 4'd1);
  assign row     = cy_q + DIMW'(ky_q);
  assign col     = cx_q + DIMW'(kx_q);
  assign rd_addr_c = ib_q + AW'(row) * AW'(w_q) + AW'(col);

  // Next window fits if its far edge stays inside the tile.
  assign col_fits = ({1'b0, cx_q} + CW'(s_q) + CW'(k_q)) <= {1'b0, w_q};
  assign row_fits = ({1'b0, cy_q} + CW'(s_q) + CW'(k_q)) <= {1'b0, h_q};

  assign bad_cfg = (kernel == 4'd0) || (stride == 4'd0) ||
                   (DIMW'(kernel) > in_w) || (DIMW'(kernel) > in_h);

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    s_d        = s_q;
    w_d        = w_q;
    h_d        = h_q;
    ib_d       = ib_q;
    ob_d       = ob_q;
    kx_d       = kx_q;
    ky_d       = ky_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    win_d      = win_q;
    data_d     = data_q;
    wd_d       = wd_q;
    err_d      = err_q;
    rd_en      = 1'b0;
    data_valid = 1'b0;
    pool_valid = 1'b0;
    wr_en      = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          k_d     = kernel;
          s_d     = stride;
          w_d     = in_w;
          h_d     = in_h;
          ib_d    = in_base;
          ob_d    = out_base;
          kx_d    = '0;
          ky_d    = '0;
          cx_d    = '0;
          cy_d    = '0;
          win_d   = '0;
          err_d   = bad_cfg;
          state_d = bad_cfg ? S_DONE : S_RD;
        end
      end
      S_RD: begin
        rd_en   = 1'b1;
        state_d = S_LAT;
      end
      S_LAT: begin
        data_d  = rd_data;
        state_d = S_SEND;
      end
      S_SEND: begin
        data_valid = 1'b1;
        pool_valid = kx_last && ky_last;
        if (data_ready) begin
          if (kx_last && ky_last) begin
            kx_d    = '0;
            ky_d    = '0;
            state_d = S_DRAIN;
          end else if (kx_last) begin
            kx_d    = '0;
            ky_d    = ky_q + 4'd1;
            state_d = S_RD;
          end else begin
            kx_d    = kx_q + 4'd1;
            state_d = S_RD;
          end
        end
      end
      S_DRAIN: begin
        if (cmp_ready) begin
          wd_d    = result;
          state_d = S_WR;
        end
      end
      S_WR: begin
        wr_en = 1'b1;
        win_d = win_q + AW'(1);
        if (col_fits) begin
          cx_d    = cx_q + DIMW'(s_q);
          state_d = S_RD;
        end else if (row_fits) begin
          cx_d    = '0;
          cy_d    = cy_q + DIMW'(s_q);
          state_d = S_RD;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign rd_addr = rd_en ? rd_addr_c : '0;
  assign wr_addr = wr_en ? (ob_q + win_q) : '0;
  assign data    = data_q;
  assign wr_data = wd_q;
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      s_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      ib_q    <= '0;
      ob_q    <= '0;
      kx_q    <= '0;
      ky_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      win_q   <= '0;
      data_q  <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      s_q     <= s_d;
      w_q     <= w_d;
      h_q     <= h_d;
      ib_q    <= ib_d;
      ob_q    <= ob_d;
      kx_q    <= kx_d;
      ky_q    <= ky_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      win_q   <= win_d;
      data_q  <= data_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

endmodule
